// File: rtl/mmu_responder_pkg.sv
// Shared types for the mmu_* responder: width encodings, latched request and lane extraction.
// Pure definitions; no clocked logic.
package mmu_responder_pkg;

  localparam logic [1:0] MMU_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MMU_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;

  typedef struct packed {
    logic        we;
    logic        sgn;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mmu_req_t;

  // Pulls the addressed byte/half out of a RAM word and extends it; width 11 behaves as word.
  function automatic logic [31:0] mmu_extract(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [1:0] width, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (width)
      MMU_WIDTH_BYTE: r = {{24{sgn & b[7]}}, b};
      MMU_WIDTH_HALF: r = {{16{sgn & h[15]}}, h};
      default:        r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmu_responder_if.sv
// CPU-side mmu_* request/response bundle; master is the CPU, slave is the responder.
// Request is a level held by the CPU; completion is the one-cycle mmu_mem_ready pulse.
interface mmu_responder_if;
  logic        mmu_read_enable;
  logic        mmu_write_enable;
  logic        mmu_mem_signed_read;
  logic [1:0]  mmu_mem_data_width;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic        mmu_mem_ready;
  logic [31:0] mmu_data_out;
  logic        mmu_mem_error;

  modport master (
    output mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
           mmu_mem_data_width, mmu_address, mmu_data_in,
    input  mmu_mem_ready, mmu_data_out, mmu_mem_error
  );

  modport slave (
    input  mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
           mmu_mem_data_width, mmu_address, mmu_data_in,
    output mmu_mem_ready, mmu_data_out, mmu_mem_error
  );
endinterface

// File: rtl/mmu_responder_ram.sv
// mmu_ram: single-port word RAM with byte write enables; read data registered one cycle after rd_en_i.
// No backpressure; rdata_o holds until the next read.
module mmu_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (rd_en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mmu_responder.sv
// Memory responder for mmu_* requests: one access per LATENCY+2 cycles, ready LATENCY cycles after acceptance.
// Inputs ignored outside IDLE; define MMU_MISALIGN_TRAP_EN to flag misaligned half/word instead of aligning down.
module mmu_responder
  import mmu_responder_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 1
) (
  input logic            clk,
  input logic            reset,
  mmu_responder_if.slave bus
);
  localparam int AW    = $clog2(MEM_DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mmu_req_t         req_q, req_d;
  logic [1:0]       rd_lo_q, rd_width_q;
  logic             rd_sgn_q, zero_q, err_q;

  logic             accept, exec, trap;
  logic [1:0]       eff_lo;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic             mem_ready, ram_rd;
  logic [3:0]       ram_be;
  logic [31:0]      ram_rdata;
  logic [AW-1:0]    ram_addr;
  logic             unused_addr_hi;

  assign accept = (state_q == S_IDLE) && (bus.mmu_read_enable || bus.mmu_write_enable);
  assign exec   = (state_q == S_ACCESS) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          req_d   = '{we:    bus.mmu_write_enable,
                      sgn:   bus.mmu_mem_signed_read,
                      width: bus.mmu_mem_data_width,
                      addr:  bus.mmu_address,
                      wdata: bus.mmu_data_in};
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) cnt_d   = cnt_q - CNT_ONE;
        else             state_d = S_RESPOND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q == S_RESPOND);
    ram_rd    = exec && !req_q.we && !trap;
    ram_be    = (exec && req_q.we && !trap) ? lane_be : 4'b0000;
  end

  // Low address bits after forced alignment; under the trap build misaligned accesses never reach the RAM.
  always_comb begin
    eff_lo = req_q.addr[1:0];
    if (req_q.width[1])                     eff_lo    = 2'b00;
    else if (req_q.width == MMU_WIDTH_HALF) eff_lo[0] = 1'b0;
`ifdef MMU_MISALIGN_TRAP_EN
    trap = (req_q.width[1] && (req_q.addr[1:0] != 2'b00)) ||
           ((req_q.width == MMU_WIDTH_HALF) && req_q.addr[0]);
`else
    trap = 1'b0;
`endif
    case (req_q.width)
      MMU_WIDTH_BYTE: begin
        lane_be    = 4'b0001 << eff_lo;
        lane_wdata = {4{req_q.wdata[7:0]}};
      end
      MMU_WIDTH_HALF: begin
        lane_be    = eff_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_q.wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = req_q.wdata;
      end
    endcase
  end

  assign ram_addr       = req_q.addr[AW+1:2];
  assign unused_addr_hi = ^req_q.addr[31:AW+2];

  // Extraction parameters are captured per completed read so data_out stays stable across later requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      req_q      <= '0;
      rd_lo_q    <= 2'b00;
      rd_width_q <= MMU_WIDTH_WORD;
      rd_sgn_q   <= 1'b0;
      zero_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
      if (exec) begin
        err_q <= trap;
        if (trap) begin
          zero_q <= 1'b1;
        end else if (!req_q.we) begin
          zero_q     <= 1'b0;
          rd_lo_q    <= eff_lo;
          rd_width_q <= req_q.width;
          rd_sgn_q   <= req_q.sgn;
        end
      end
    end
  end

  mmu_ram #(.DEPTH_WORDS(MEM_DEPTH_WORDS), .AW(AW)) u_ram (
    .clk_i   (clk),
    .rd_en_i (ram_rd),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (lane_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.mmu_mem_ready = mem_ready;
  assign bus.mmu_data_out  = zero_q ? 32'h0 : mmu_extract(ram_rdata, rd_lo_q, rd_width_q, rd_sgn_q);
  assign bus.mmu_mem_error = err_q;
endmodule

// File: tb/tb_mmu_responder.sv
// Directed bench for mmu_responder: one instance at LATENCY=1, one at LATENCY=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mmu_responder;
  import mmu_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mmu_responder_if bus1 ();
  mmu_responder_if bus3 ();

  mmu_responder #(.MEM_DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mmu_responder #(.MEM_DEPTH_WORDS(1024), .LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int w, input logic re, input logic we, input logic sgn,
                         input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d);
    if (w == 3) begin
      bus3.mmu_read_enable = re; bus3.mmu_write_enable = we; bus3.mmu_mem_signed_read = sgn;
      bus3.mmu_mem_data_width = wd; bus3.mmu_address = a; bus3.mmu_data_in = d;
    end else begin
      bus1.mmu_read_enable = re; bus1.mmu_write_enable = we; bus1.mmu_mem_signed_read = sgn;
      bus1.mmu_mem_data_width = wd; bus1.mmu_address = a; bus1.mmu_data_in = d;
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 3) ? bus3.mmu_mem_ready : bus1.mmu_mem_ready;
  endfunction

  function automatic logic [31:0] dout(input int w);
    return (w == 3) ? bus3.mmu_data_out : bus1.mmu_data_out;
  endfunction

  function automatic logic derr(input int w);
    return (w == 3) ? bus3.mmu_mem_error : bus1.mmu_mem_error;
  endfunction

  // Waits for ready, counting falling edges from the one on which the request was driven.
  task automatic wait_ready(input int w, output int lat);
    bit done = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (rdy(w)) begin
        lat  = n;
        done = 1'b1;
      end
    end
    if (!done) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called on a falling edge with the DUT idle; returns on a falling edge with the DUT idle again.
  task automatic access(input int w, input logic re, input logic we, input logic sgn,
                        input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic e, output int lat);
    set_req(w, re, we, sgn, wd, a, d);
    wait_ready(w, lat);
    q = dout(w);
    e = derr(w);
    set_req(w, 1'b0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0, 32'h0);
    @(negedge clk);
    check_val("ready_one_cycle", {31'd0, rdy(w)}, 32'd0);
  endtask

  logic [31:0] q;
  logic        e;
  int          lat;
  logic [31:0] held_exp [3];

  initial begin
    set_req(1, 1'b0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0, 32'h0);
    set_req(3, 1'b0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_ready", {31'd0, bus1.mmu_mem_ready}, 32'd0);
    check_val("reset_data",  bus1.mmu_data_out, 32'h0);
    check_val("reset_error", {31'd0, bus1.mmu_mem_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    access(1, 1'b0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h20, 32'hCAFEBABE, q, e, lat);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h20, 32'h0, q, e, lat);
    check_val("pre_reset_rd20", q, 32'hCAFEBABE);

    // Reset lands inside ACCESS of a write, before the execute edge.
    set_req(1, 1'b0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h20, 32'h12345678);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", {31'd0, bus1.mmu_mem_ready}, 32'd0);
    check_val("midrst_data",  bus1.mmu_data_out, 32'h0);
    check_val("midrst_error", {31'd0, bus1.mmu_mem_error}, 32'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("postrst_ready", {31'd0, bus1.mmu_mem_ready}, 32'd0);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h20, 32'h0, q, e, lat);
    check_val("discarded_write_rd20", q, 32'hCAFEBABE);

    access(1, 1'b0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h8BADF00D, q, e, lat);
    check_val("wr_latency_l1", lat, 32'd2);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h0, q, e, lat);
    check_val("rd10_l1", q, 32'h8BADF00D);
    check_val("rd_latency_l1", lat, 32'd2);
    check_val("rd10_err", {31'd0, e}, 32'd0);

    access(3, 1'b0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h8BADF00D, q, e, lat);
    check_val("wr_latency_l3", lat, 32'd4);
    access(3, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h0, q, e, lat);
    check_val("rd10_l3", q, 32'h8BADF00D);
    check_val("rd_latency_l3", lat, 32'd4);

    access(1, 1'b1, 1'b0, 1'b1, MMU_WIDTH_BYTE, 32'h13, 32'h0, q, e, lat);
    check_val("sbyte_13", q, 32'hFFFFFF8B);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_BYTE, 32'h13, 32'h0, q, e, lat);
    check_val("ubyte_13", q, 32'h0000008B);
    access(1, 1'b1, 1'b0, 1'b1, MMU_WIDTH_HALF, 32'h12, 32'h0, q, e, lat);
    check_val("shalf_12", q, 32'hFFFF8BAD);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_HALF, 32'h10, 32'h0, q, e, lat);
    check_val("uhalf_10", q, 32'h0000F00D);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_BYTE, 32'h10, 32'h0, q, e, lat);
    check_val("ubyte_10", q, 32'h0000000D);

    access(1, 1'b0, 1'b1, 1'b0, MMU_WIDTH_BYTE, 32'h11, 32'h000000AA, q, e, lat);
    check_val("bytewr_keeps_dout", q, 32'h0000000D);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h0, q, e, lat);
    check_val("after_bytewr", q, 32'h8BADAA0D);
    access(1, 1'b0, 1'b1, 1'b0, MMU_WIDTH_HALF, 32'h12, 32'h00001234, q, e, lat);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h10, 32'h0, q, e, lat);
    check_val("after_halfwr", q, 32'h1234AA0D);

    held_exp[0] = 32'h11111111;
    held_exp[1] = 32'h22222222;
    held_exp[2] = 32'h33333333;
    for (int i = 0; i < 3; i++)
      access(1, 1'b0, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'(4 * i), held_exp[i], q, e, lat);

    // Read enable stays high; the address advances on the falling edge where ready is seen.
    set_req(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      wait_ready(1, lat);
      check_val($sformatf("held_rd%0d", i), bus1.mmu_data_out, held_exp[i]);
      check_val($sformatf("held_gap%0d", i), lat, (i == 0) ? 32'd2 : 32'd3);
      if (i < 2) bus1.mmu_address = 32'(4 * (i + 1));
    end
    set_req(1, 1'b0, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h0, 32'h0);
    @(negedge clk);
    check_val("held_end_ready", {31'd0, bus1.mmu_mem_ready}, 32'd0);

    access(1, 1'b1, 1'b1, 1'b0, MMU_WIDTH_WORD, 32'h8, 32'hDEADBEEF, q, e, lat);
    check_val("both_en_dout", q, 32'h33333333);
    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h8, 32'h0, q, e, lat);
    check_val("both_en_written", q, 32'hDEADBEEF);

    access(1, 1'b1, 1'b0, 1'b0, MMU_WIDTH_WORD, 32'h12, 32'h0, q, e, lat);
    check_val("misalign_latency", lat, 32'd2);
`ifdef MMU_MISALIGN_TRAP_EN
    check_val("misalign_err",  {31'd0, e}, 32'd1);
    check_val("misalign_data", q, 32'h0);
`else
    check_val("misalign_err",  {31'd0, e}, 32'd0);
    check_val("misalign_data", q, 32'h1234AA0D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
